proc_ctrl: RTL and testbench

Control FSM for the multi-cycle 16-bit processor datapath: the eight general registers, A, G, IR, ALU and bus multiplexer. It samples Run, loads the instruction register, and decodes the 9-bit instruction. For each time step it drives the register-in/out enables, the bus source select and the ALU operation. It pulses Done on the final step and keeps a retired-instruction counter. It replaces the inline control logic in the top-level processor; the datapath instantiates it and consumes its enables directly.

---
 rtl/proc_pkg.sv | 42 ++++
 rtl/proc_ctrl_if.sv | 32 +++
 rtl/proc_ctrl_dec3to8.sv | 11 +
 rtl/proc_ctrl.sv | 112 +++++++++++
 tb/tb_proc_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, FSM state encoding and ALU op codes shared by the control FSM and the ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Optional feature macro: PROC_CTRL_AND_EN (adds opcode 100 "and" to the ALU-op decode).
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_e;

  // True for opcodes that use the three-step A/G sequence.
  function automatic logic is_alu_op(input logic [2:0] op);
`ifdef PROC_CTRL_AND_EN
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
`else
    return (op == OP_ADD) || (op == OP_SUB);
`endif
  endfunction

  // ALU operation for the T2 step of an ALU instruction.
  function automatic logic [1:0] alu_op_of(input logic [2:0] op);
`ifdef PROC_CTRL_AND_EN
    if (op == OP_AND) return ALU_AND;
`endif
    if (op == OP_SUB) return ALU_SUB;
    return ALU_ADD;
  endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// proc_ctrl_if: control bundle between proc_ctrl and the datapath (Run/IR in, enables out).
// Latency: wires only; enables are valid in the cycle they are driven.
// Backpressure: none; the datapath consumes every enable on the next rising edge.
// Ports: Run, IR (datapath -> ctrl); IRin, Rin, Rout, DINout, Ain, Gin, Gout, AluOp, Done, Busy,
//        InstrCount (ctrl -> datapath). master = controller side, slave = datapath side.
interface proc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             Run;
  logic [8:0]       IR;
  logic             IRin;
  logic [7:0]       Rin;
  logic [7:0]       Rout;
  logic             DINout;
  logic             Ain;
  logic             Gin;
  logic             Gout;
  logic [1:0]       AluOp;
  logic             Done;
  logic             Busy;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Run, IR,
    output IRin, Rin, Rout, DINout, Ain, Gin, Gout, AluOp, Done, Busy, InstrCount
  );

  modport slave (
    output Run, IR,
    input  IRin, Rin, Rout, DINout, Ain, Gin, Gout, AluOp, Done, Busy, InstrCount
  );
endinterface

// File: rtl/proc_ctrl_dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder with enable, used for the X and Y register selects.
// Latency: combinational.
// Backpressure: none.
// Ports: w (3-bit index), en (enable), y (one-hot, all zero when en=0).
module dec3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] y
);
  assign y = en ? (8'b1 << w) : 8'b0;
endmodule

// File: rtl/proc_ctrl.sv
// proc_ctrl: multi-cycle control FSM (IDLE/T1/T2/T3) driving register enables, bus select and ALU op.
// Latency: fetch + 1 step for mv/mvi/NOP, fetch + 3 steps for ALU ops; outputs combinational from state+IR.
// Backpressure: none; Run is sampled only in IDLE, back-to-back issue when Run stays high.
// Ports: Clock, Resetn (async active-low), bus (proc_ctrl_if.master).
// Optional feature macro: PROC_CTRL_AND_EN enables opcode 100 as "and"; otherwise it is a NOP.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  proc_ctrl_if.master  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] op;
  logic       alu_instr;
  logic       rin_x, rout_x, rout_y;
  logic       irin, dinout, ain, gin, gout, done;
  logic [1:0] aluop;
  logic [7:0] x_sel, y_sel;

  assign op        = bus.IR[8:6];
  assign alu_instr = is_alu_op(op);

  always_comb begin
    state_d = state_q;
    irin    = 1'b0;
    rin_x   = 1'b0;
    rout_x  = 1'b0;
    rout_y  = 1'b0;
    dinout  = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    aluop   = ALU_ADD;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gated by Resetn so IRin is already low while reset is asserted.
        irin = bus.Run & Resetn;
        if (bus.Run) state_d = S_T1;
      end
      S_T1: begin
        if (op == OP_MV) begin
          rout_y  = 1'b1;
          rin_x   = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (op == OP_MVI) begin
          dinout  = 1'b1;
          rin_x   = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (alu_instr) begin
          rout_x  = 1'b1;
          ain     = 1'b1;
          state_d = S_T2;
        end else begin
          // Illegal or disabled opcode: retire as a NOP with nothing on the bus.
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_T2: begin
        rout_y  = 1'b1;
        gin     = 1'b1;
        aluop   = alu_op_of(op);
        state_d = S_T3;
      end
      S_T3: begin
        gout    = 1'b1;
        rin_x   = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, done};

  dec3to8 u_dec_x (.w(bus.IR[5:3]), .en(rin_x | rout_x), .y(x_sel));
  dec3to8 u_dec_y (.w(bus.IR[2:0]), .en(rout_y),         .y(y_sel));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.IRin       = irin;
  assign bus.Rin        = rin_x ? x_sel : 8'b0;
  // X and Y selects never drive in the same step, so OR-ing keeps Rout one-hot.
  assign bus.Rout       = (rout_x ? x_sel : 8'b0) | y_sel;
  assign bus.DINout     = dinout;
  assign bus.Ain        = ain;
  assign bus.Gin        = gin;
  assign bus.Gout       = gout;
  assign bus.AluOp      = aluop;
  assign bus.Done       = done;
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.InstrCount = cnt_q;

endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: table-driven and randomized checks of proc_ctrl against a per-instruction step model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_proc_ctrl;

  typedef struct packed {
    logic       IRin;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       DINout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [1:0] AluOp;
    logic       Done;
    logic       Busy;
  } out_t;

  typedef struct {
    string          name;
    logic [8:0]     ir;
    int             n;
    out_t [3:0]     exp;
  } vec_t;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;
  logic [3:0] model_cnt;
  out_t eseq[4];
  int   en;
  vec_t tbl[9];

  proc_ctrl_if #(.CNT_W(4)) bus ();
  proc_ctrl #(.CNT_W(4)) dut (.Clock(clk), .Resetn(rstn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                              input logic din, input logic ain, input logic gin, input logic gout,
                              input logic [1:0] alu, input logic done, input logic busy);
    out_t o;
    o.IRin = irin; o.Rin = rin; o.Rout = rout; o.DINout = din; o.Ain = ain;
    o.Gin = gin; o.Gout = gout; o.AluOp = alu; o.Done = done; o.Busy = busy;
    return o;
  endfunction

  function automatic out_t dut_out();
    return mk(bus.IRin, bus.Rin, bus.Rout, bus.DINout, bus.Ain, bus.Gin, bus.Gout,
              bus.AluOp, bus.Done, bus.Busy);
  endfunction

  task automatic check_out(input string name, input out_t exp);
    out_t got;
    got = dut_out();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (IRin,Rin,Rout,DINout,Ain,Gin,Gout,AluOp,Done,Busy)",
               name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name);
    tests++;
    if (bus.InstrCount !== model_cnt) begin
      fails++;
      $display("FAIL %s count: got %0d want %0d", name, bus.InstrCount, model_cnt);
    end
  endtask

  // Reference: expected per-cycle outputs from fetch to Done, built from the instruction rules.
  task automatic model(input logic [8:0] ir);
    logic [2:0] op;
    logic [7:0] xo, yo;
    logic       is_alu;
    op = ir[8:6];
    xo = 8'd1 << ir[5:3];
    yo = 8'd1 << ir[2:0];
`ifdef PROC_CTRL_AND_EN
    is_alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
`else
    is_alu = (op == 3'd2) || (op == 3'd3);
`endif
    eseq[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eseq[1] = '0; eseq[2] = '0; eseq[3] = '0;
    if (op == 3'd0) begin
      eseq[1] = mk(0, xo, yo, 0, 0, 0, 0, 0, 1, 1); en = 2;
    end else if (op == 3'd1) begin
      eseq[1] = mk(0, xo, 0, 1, 0, 0, 0, 0, 1, 1); en = 2;
    end else if (is_alu) begin
      eseq[1] = mk(0, 0, xo, 0, 1, 0, 0, 0, 0, 1);
      eseq[2] = mk(0, 0, yo, 0, 0, 1, 0, (op == 3'd2) ? 2'd0 : (op == 3'd3) ? 2'd1 : 2'd2, 0, 1);
      eseq[3] = mk(0, xo, 0, 0, 0, 0, 1, 0, 1, 1);
      en = 4;
    end else begin
      eseq[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); en = 2;
    end
  endtask

  // Entered just after a rising edge with the FSM in IDLE; leaves just after the edge ending Done.
  task automatic exec(input logic [8:0] ir, input bit keep_run, input string tag);
    bus.Run = 1'b1;
    bus.IR  = ir;
    for (int i = 0; i < en; i++) begin
      @(negedge clk);
      check_out($sformatf("%s step%0d", tag, i), eseq[i]);
      if (i == 0) check_cnt(tag);
      if (eseq[i].Done) model_cnt = model_cnt + 4'd1;
      @(posedge clk); #1;
      bus.Run = (i == en - 1) ? keep_run : 1'($urandom);
    end
  endtask

  task automatic idle_cycle(input string tag);
    bus.Run = 1'b0;
    @(negedge clk);
    check_out(tag, '0);
    check_cnt(tag);
    @(posedge clk); #1;
  endtask

  // Bus rule: never more than one driver.
  always @(negedge clk) begin
    tests++;
    if ($countones({bus.Rout, bus.DINout, bus.Gout}) > 1) begin
      fails++;
      $display("FAIL bus_onehot: got Rout=%b DINout=%b Gout=%b want at most one", bus.Rout,
               bus.DINout, bus.Gout);
    end
  end

  initial begin
    out_t fch;
    tests = 0; fails = 0; model_cnt = 4'd0; en = 0;
    fch = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0] = '{"mvi_r3",   9'b001_011_000, 2, '{default: '0}};
    tbl[0].exp[1] = mk(0, 8'h08, 0, 1, 0, 0, 0, 0, 1, 1);
    tbl[1] = '{"add_r1r2", 9'b010_001_010, 4, '{default: '0}};
    tbl[1].exp[1] = mk(0, 0, 8'h02, 0, 1, 0, 0, 2'b00, 0, 1);
    tbl[1].exp[2] = mk(0, 0, 8'h04, 0, 0, 1, 0, 2'b00, 0, 1);
    tbl[1].exp[3] = mk(0, 8'h02, 0, 0, 0, 0, 1, 2'b00, 1, 1);
    tbl[2] = '{"sub_r5r6", 9'b011_101_110, 4, '{default: '0}};
    tbl[2].exp[1] = mk(0, 0, 8'h20, 0, 1, 0, 0, 2'b00, 0, 1);
    tbl[2].exp[2] = mk(0, 0, 8'h40, 0, 0, 1, 0, 2'b01, 0, 1);
    tbl[2].exp[3] = mk(0, 8'h20, 0, 0, 0, 0, 1, 2'b00, 1, 1);
    tbl[3] = '{"mv_r0r7",  9'b000_000_111, 2, '{default: '0}};
    tbl[3].exp[1] = mk(0, 8'h01, 8'h80, 0, 0, 0, 0, 0, 1, 1);
    tbl[4] = '{"mv_r3r3",  9'b000_011_011, 2, '{default: '0}};
    tbl[4].exp[1] = mk(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 1);
    tbl[5] = '{"add_r2r2", 9'b010_010_010, 4, '{default: '0}};
    tbl[5].exp[1] = mk(0, 0, 8'h04, 0, 1, 0, 0, 2'b00, 0, 1);
    tbl[5].exp[2] = mk(0, 0, 8'h04, 0, 0, 1, 0, 2'b00, 0, 1);
    tbl[5].exp[3] = mk(0, 8'h04, 0, 0, 0, 0, 1, 2'b00, 1, 1);
`ifdef PROC_CTRL_AND_EN
    tbl[6] = '{"and_r6r1", 9'b100_110_001, 4, '{default: '0}};
    tbl[6].exp[1] = mk(0, 0, 8'h40, 0, 1, 0, 0, 2'b00, 0, 1);
    tbl[6].exp[2] = mk(0, 0, 8'h02, 0, 0, 1, 0, 2'b10, 0, 1);
    tbl[6].exp[3] = mk(0, 8'h40, 0, 0, 0, 0, 1, 2'b00, 1, 1);
`else
    tbl[6] = '{"op100_nop", 9'b100_110_001, 2, '{default: '0}};
    tbl[6].exp[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
`endif
    tbl[7] = '{"op111_nop", 9'b111_010_011, 2, '{default: '0}};
    tbl[7].exp[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[8] = '{"op101_nop", 9'b101_100_101, 2, '{default: '0}};
    tbl[8].exp[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) tbl[i].exp[0] = fch;

    // Reset state: all outputs low even with Run high.
    rstn = 1'b0; bus.Run = 1'b1; bus.IR = 9'b001_011_000;
    #3;
    check_out("reset_outs", '0);
    check_cnt("reset");
    @(posedge clk); #1;
    check_out("reset_outs_edge", '0);
    bus.Run = 1'b0;
    rstn = 1'b1;
    idle_cycle("idle_run0");

    // Table: back-to-back issue, next fetch the cycle after Done.
    for (int t = 0; t < 9; t++) begin
      en = tbl[t].n;
      for (int s = 0; s < 4; s++) eseq[s] = tbl[t].exp[s];
      exec(tbl[t].ir, (t != 8), tbl[t].name);
    end
    idle_cycle("idle_after_table");

    // Reset during T2 of an add.
    bus.Run = 1'b1; bus.IR = 9'b010_001_010;
    @(negedge clk); check_out("rst_add fetch", fch);
    @(posedge clk); #1; bus.Run = 1'b0;
    @(negedge clk); check_out("rst_add T1", tbl[1].exp[1]);
    @(posedge clk); #1; bus.Run = 1'b1;
    #1; check_out("rst_add T2", tbl[1].exp[2]);
    rstn = 1'b0;
    #1; check_out("rst_add async", '0);
    model_cnt = 4'd0;
    check_cnt("rst_add async");
    @(posedge clk); #1;
    check_out("rst_add held", '0);
    rstn = 1'b1;
    model(9'b001_011_000);
    exec(9'b001_011_000, 1'b0, "post_rst_mvi");
    idle_cycle("post_rst_idle");

    // Counter wrap through 15 -> 0 with mv instructions.
    while (model_cnt != 4'd15) begin
      model(9'b000_010_101);
      exec(9'b000_010_101, 1'b1, "wrap_mv");
    end
    check_cnt("wrap_at15");
    model(9'b000_111_000);
    exec(9'b000_111_000, 1'b0, "wrap_last");
    idle_cycle("wrap_zero");

    // Randomized stream with idle gaps and Run noise during steps.
    for (int k = 0; k < 300; k++) begin
      logic [8:0] ir;
      bit         kr;
      ir = 9'($urandom);
      kr = 1'($urandom);
      model(ir);
      exec(ir, kr, $sformatf("rnd%0d", k));
      if (!kr) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) idle_cycle($sformatf("rnd%0d gap", k));
      end
    end
    bus.Run = 1'b0;
    idle_cycle("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
